// File: rtl/mux_rr_sequencer_pkg.sv
// Shared sizing and FSM state type for the round-robin mux sequencer.
// The channel count must be a power of two so that channel ids wrap naturally.
package mux_rr_sequencer_pkg;

    localparam int N_CH   = 4;
    localparam int DATA_W = 4;
    localparam int SEL_W  = $clog2(N_CH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/mux_rr_sequencer_if.sv
// Channel-side and consumer-side signals of the sequencer, bundled for port connection.
// master = the sequencer itself, slave = the channel sources, the mux and the consumer.
interface mux_rr_sequencer_if;
    import mux_rr_sequencer_pkg::*;

    logic [N_CH-1:0]   req;
    logic [N_CH-1:0]   ack;
    logic [SEL_W-1:0]  select;
    logic [DATA_W-1:0] mux_out;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [SEL_W-1:0]  m_ch;

    modport master (
        input  req, mux_out, m_ready,
        output ack, select, m_valid, m_data, m_ch
    );

    modport slave (
        output req, mux_out, m_ready,
        input  ack, select, m_valid, m_data, m_ch
    );

endinterface

// File: rtl/mux_rr_sequencer_rr_pick.sv
// Combinational round-robin picker: first requesting channel after ptr_i, wrapping.
// Searching from the farthest offset down lets the nearest hit overwrite the others.
module mux_rr_sequencer_rr_pick
    import mux_rr_sequencer_pkg::*;
(
    input  logic [N_CH-1:0]  req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [SEL_W-1:0] winner_o,
    output logic             any_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        winner_o = ptr_i;
        for (int i = N_CH; i >= 1; i--) begin
            if (req_i[ptr_i + SEL_W'(i)]) begin
                winner_o = ptr_i + SEL_W'(i);
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/mux_rr_sequencer.sv
// Round-robin sequencer for the external 4:1 mux: grants a channel, samples the mux
// one cycle later and presents the sample on a valid/ready port with a one-cycle ack.
module mux_rr_sequencer
    import mux_rr_sequencer_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    mux_rr_sequencer_if.master bus
);

    seq_state_t        state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  select_q, select_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [SEL_W-1:0]  m_ch_q, m_ch_d;
    logic [N_CH-1:0]   ack_q, ack_d;

    logic [SEL_W-1:0]  winner;
    logic              any;

    mux_rr_sequencer_rr_pick u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .any_o    (any)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        select_d  = select_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ch_d    = m_ch_q;
        ack_d     = '0;

        case (state_q)
            IDLE: begin
                if (any) begin
                    select_d = winner;
                    ptr_d    = winner;
                    state_d  = SAMPLE;
                end
            end
            // Capture is unconditional: a request dropped after arbitration still yields its item.
            SAMPLE: begin
                m_data_d  = bus.mux_out;
                m_ch_d    = select_q;
                m_valid_d = 1'b1;
                ack_d     = N_CH'(1) << select_q;
                state_d   = HOLD;
            end
            HOLD: begin
                if (m_valid_q && bus.m_ready) begin
                    m_valid_d = 1'b0;
                    if (any) begin
                        select_d = winner;
                        ptr_d    = winner;
                        state_d  = SAMPLE;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= SEL_W'(N_CH - 1);
            select_q  <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ch_q    <= '0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            select_q  <= select_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ch_q    <= m_ch_d;
            ack_q     <= ack_d;
        end
    end

    assign bus.select  = select_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_ch    = m_ch_q;
    assign bus.ack     = ack_q;

endmodule

// File: tb/tb_mux_rr_sequencer.sv
// Bench for mux_rr_sequencer with a behavioural 4:1 mux and a transaction-rule reference model.
module tb_mux_rr_sequencer;
    import mux_rr_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_rr_sequencer_if bus ();
    mux_rr_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // The mux is purely combinational, one word per channel
    logic [N_CH-1:0][DATA_W-1:0] in_data;
    assign bus.mux_out = in_data[bus.select];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: stage 0 = waiting for a request, 1 = granted, 2 = item on output
    int                md_stage, md_ptr, md_sel, md_ch;
    logic              md_valid;
    logic [DATA_W-1:0] md_data;
    logic [N_CH-1:0]   md_ack;
    logic              prev_valid, ready_at_edge;
    logic [DATA_W-1:0] prev_data;

    function automatic int pick(input logic [N_CH-1:0] r, input int p);
        for (int off = 1; off <= N_CH; off++) begin
            int c = (p + off) % N_CH;
            if (r[c]) return c;
        end
        return p;
    endfunction

    task automatic model_reset();
        md_stage = 0; md_ptr = N_CH - 1; md_sel = 0; md_ch = 0;
        md_valid = 1'b0; md_data = '0; md_ack = '0;
        prev_valid = 1'b0; prev_data = '0; ready_at_edge = 1'b0;
    endtask

    task automatic compare();
        check("select",  bus.select,  md_sel);
        check("m_valid", bus.m_valid, md_valid);
        check("m_data",  bus.m_data,  md_data);
        check("m_ch",    bus.m_ch,    md_ch);
        check("ack",     bus.ack,     md_ack);
        check("ack_onehot0", $onehot0(bus.ack), 1);
        if (bus.ack != '0) check("ack_on_rising_valid", bus.m_valid && !prev_valid, 1);
        if (prev_valid && !ready_at_edge) begin
            check("hold_valid", bus.m_valid, 1);
            check("hold_data",  bus.m_data,  prev_data);
        end
        prev_valid = bus.m_valid;
        prev_data  = bus.m_data;
    endtask

    // Inputs are already set (at a falling edge); advance one rising edge and compare.
    task automatic cycle();
        logic [N_CH-1:0]   r;
        int                n_stage, n_ptr, n_sel, n_ch;
        logic              n_valid;
        logic [DATA_W-1:0] n_data;
        logic [N_CH-1:0]   n_ack;
        r = bus.req;
        n_stage = md_stage; n_ptr = md_ptr; n_sel = md_sel; n_ch = md_ch;
        n_valid = md_valid; n_data = md_data; n_ack = '0;
        case (md_stage)
            0: if (r != '0) begin
                n_sel = pick(r, md_ptr); n_ptr = n_sel; n_stage = 1;
            end
            1: begin
                n_data = in_data[md_sel]; n_ch = md_sel; n_valid = 1'b1;
                n_ack = N_CH'(1) << md_sel; n_stage = 2;
            end
            default: if (bus.m_ready) begin
                n_valid = 1'b0;
                if (r != '0) begin
                    n_sel = pick(r, md_ptr); n_ptr = n_sel; n_stage = 1;
                end else begin
                    n_stage = 0;
                end
            end
        endcase
        ready_at_edge = bus.m_ready;
        @(posedge clk);
        md_stage = n_stage; md_ptr = n_ptr; md_sel = n_sel; md_ch = n_ch;
        md_valid = n_valid; md_data = n_data; md_ack = n_ack;
        @(negedge clk);
        compare();
    endtask

    // Reset asserted between edges; outputs must clear before the next rising edge.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1 model_reset();
        compare();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int acks;
        int exp_ch[5] = '{0, 1, 2, 3, 0};
        int item;

        bus.req = '0; bus.m_ready = 1'b0; in_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        rst_n = 1'b1;

        // Reset and first grant
        bus.req = 4'b1111; bus.m_ready = 1'b1;
        cycle();
        check("t1_first_sel", bus.select, 0);
        cycle();
        check("t1_first_ch", bus.m_ch, 0);
        cycle();
        do_reset();
        check("t1_rst_valid", bus.m_valid, 0);

        // Single request
        bus.req = 4'b0010; in_data[1] = 4'hA; bus.m_ready = 1'b1;
        cycle();
        check("t2_sel", bus.select, 1);
        check("t2_valid_early", bus.m_valid, 0);
        cycle();
        check("t2_valid", bus.m_valid, 1);
        check("t2_data", bus.m_data, 4'hA);
        check("t2_ch", bus.m_ch, 1);
        check("t2_ack", bus.ack, 4'b0010);
        bus.req = '0;
        cycle();
        check("t2_valid_drop", bus.m_valid, 0);
        check("t2_ack_drop", bus.ack, 0);

        // Fairness with all channels requesting
        do_reset();
        for (int i = 0; i < N_CH; i++) in_data[i] = DATA_W'(i + 1);
        bus.req = 4'b1111; bus.m_ready = 1'b1;
        item = 0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            check("t3_valid_pat", bus.m_valid, (k % 2 == 0));
            if (bus.m_valid && item < 5) begin
                check("t3_ch_seq", bus.m_ch, exp_ch[item]);
                check("t3_data", bus.m_data, exp_ch[item] + 1);
                item++;
            end
        end
        check("t3_items", item, 5);

        // Backpressure
        do_reset();
        bus.req = 4'b0010; in_data[1] = 4'h5; bus.m_ready = 1'b0;
        cycle(); cycle();
        acks = (bus.ack != '0) ? 1 : 0;
        for (int k = 0; k < 5; k++) begin
            in_data[1] = DATA_W'($urandom);
            cycle();
            check("t4_data", bus.m_data, 4'h5);
            check("t4_valid", bus.m_valid, 1);
            check("t4_sel", bus.select, 1);
            if (bus.ack != '0) acks++;
        end
        check("t4_ack_pulses", acks, 1);
        bus.m_ready = 1'b1;
        cycle();
        check("t4_release", bus.m_valid, 0);

        // Skip idle channels, then a request dropped after grant
        do_reset();
        bus.req = 4'b0001; bus.m_ready = 1'b1;
        cycle(); cycle();
        bus.req = 4'b1001;
        cycle();
        check("t5_sel3", bus.select, 3);
        cycle();
        check("t5_ch3", bus.m_ch, 3);
        cycle();
        check("t5_sel0", bus.select, 0);
        cycle();
        check("t5_ch0", bus.m_ch, 0);
        bus.req = 4'b1000;
        cycle();
        bus.req = '0;
        cycle();
        check("t5_drop_valid", bus.m_valid, 1);
        check("t5_drop_ch", bus.m_ch, 3);
        check("t5_drop_ack", bus.ack, 4'b1000);

        // Reset while an item is held
        do_reset();
        bus.req = 4'b0100; bus.m_ready = 1'b0;
        cycle(); cycle();
        check("t6_held", bus.m_valid, 1);
        do_reset();
        check("t6_valid", bus.m_valid, 0);
        check("t6_ack", bus.ack, 0);
        bus.req = 4'b1111; bus.m_ready = 1'b1;
        cycle();
        check("t6_ptr_wrap", bus.select, 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            bus.req     = N_CH'($urandom);
            bus.m_ready = ($urandom_range(0, 3) != 0);
            in_data     = (N_CH * DATA_W)'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
